rr_handshake_merge: RTL and testbench

- Upstream feeder of the handshake/data slave (`in1`, `handshake_valid`/`handshake_ready`).
- Merges N ready/valid producer channels (the `handshake_arr_*` lanes) into one output stream.
- Arbitration is round-robin; a 2-entry FIFO decouples it from backpressure.
- Output is registered, so `out_valid`/`out_data` never depend combinationally on `out_ready`.

---
 rtl/rr_merge_pkg.sv | 49 ++++
 rtl/rr_merge_fifo.sv | 82 ++++++++
 rtl/rr_handshake_merge.sv | 85 ++++++++
 tb/tb_rr_handshake_merge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_merge_pkg.sv
// Shared types and the round-robin pick helper for the handshake merge.
package rr_merge_pkg;

    // Default configuration of the merge.
    localparam int unsigned DEF_WIDTH = 5;
    localparam int unsigned DEF_N     = 3;
    localparam int unsigned DEF_DEPTH = 2;

    localparam int unsigned SRC_W = $clog2(DEF_N);
    localparam int unsigned OCC_W = $clog2(DEF_DEPTH) + 1;

    // Largest supported channel count and the index width that covers it.
    localparam int unsigned MAX_N = 8;
    localparam int unsigned IDX_W = 3;

    // FIFO payload: originating channel plus the channel's data word.
    typedef struct packed {
        logic [SRC_W-1:0]     src;
        logic [DEF_WIDTH-1:0] data;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    // Result of a round-robin pick.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First asserted valid at or after prio, scanning upward modulo n.
    function automatic pick_t rr_pick(
        input logic [MAX_N-1:0] valid,
        input logic [IDX_W-1:0] prio,
        input logic [IDX_W:0]   n
    );
        pick_t            r;
        logic [IDX_W-1:0] cand;
        r = '0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            cand = IDX_W'((32'(prio) + k) % 32'(n));
            if (k < 32'(n) && !r.found && valid[cand]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_merge_fifo.sv
// Small circular FIFO between the arbiter and the output port.
module rr_merge_fifo
    import rr_merge_pkg::*;
#(
    parameter int unsigned ENTRY_W = rr_merge_pkg::ENTRY_W,
    parameter int unsigned DEPTH   = DEF_DEPTH
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ENTRY_W-1:0]     data_in,
    output logic [ENTRY_W-1:0]     data_out,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [FILL_W-1:0]  occ_q;

    logic push_ok_c;
    logic pop_ok_c;

    // Status flags straight from the fill register.
    assign full      = (occ_q == FILL_W'(DEPTH));
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign data_out  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok_c = push & (~full | pop);
    assign pop_ok_c  = pop & ~empty;

    // Storage array; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Write pointer, wrapping from DEPTH-1 back to 0.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_ptr_q <= '0;
        end else if (push_ok_c) begin
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
    end

    // Read pointer, wrapping from DEPTH-1 back to 0.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rd_ptr_q <= '0;
        end else if (pop_ok_c) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    // Fill count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            occ_q <= '0;
        end else begin
            case ({push_ok_c, pop_ok_c})
                2'b10:   occ_q <= occ_q + FILL_W'(1);
                2'b01:   occ_q <= occ_q - FILL_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/rr_handshake_merge.sv
// Round-robin merge of N ready/valid channels into one registered output stream.
module rr_handshake_merge
    import rr_merge_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N     = DEF_N,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    input  logic [N*WIDTH-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_src,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned SRC_BITS   = $clog2(N);
    localparam int unsigned ENTRY_BITS = SRC_BITS + WIDTH;

    logic [SRC_BITS-1:0]   prio_q;
    pick_t                 pick_c;
    logic [SRC_BITS-1:0]   grant_c;
    logic                  can_push_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_BITS-1:0] fifo_din_c;
    logic [ENTRY_BITS-1:0] fifo_dout;

    // Arbitration: first requester at or after the priority pointer.
    always_comb begin
        pick_c  = rr_pick(MAX_N'(in_valid), IDX_W'(prio_q), (IDX_W + 1)'(N));
        grant_c = SRC_BITS'(pick_c.idx);
    end

    // Head is presented whenever the FIFO holds anything.
    assign out_valid  = ~fifo_empty;
    assign pop_c      = out_valid & out_ready;
    assign can_push_c = ~fifo_full | pop_c;

    // Ready goes only to the granted channel, and never while in reset.
    always_comb begin
        in_ready = '0;
        if (ASYNCRESETN && pick_c.found && can_push_c) begin
            in_ready[grant_c] = 1'b1;
        end
    end

    assign push_c     = |(in_valid & in_ready);
    assign fifo_din_c = {grant_c, in_data[32'(grant_c) * WIDTH +: WIDTH]};

    // Priority pointer moves just past the last accepted channel.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            prio_q <= '0;
        end else if (push_c) begin
            prio_q <= (32'(grant_c) == N - 1) ? '0 : grant_c + SRC_BITS'(1);
        end
    end

    rr_merge_fifo #(
        .ENTRY_W (ENTRY_BITS),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .push        (push_c),
        .pop         (pop_c),
        .data_in     (fifo_din_c),
        .data_out    (fifo_dout),
        .occupancy   (occupancy),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // Split the head entry back into source index and payload.
    assign out_data = fifo_dout[WIDTH-1:0];
    assign out_src  = fifo_dout[ENTRY_BITS-1 -: SRC_BITS];

endmodule

// File: tb/tb_rr_handshake_merge.sv
// Directed bench for rr_handshake_merge with a queue-based reference model.
module tb_rr_handshake_merge;

    localparam int WIDTH = 5;
    localparam int N     = 3;
    localparam int DEPTH = 2;
    localparam int SRC_W = 2;
    localparam int OCC_W = 2;

    logic               CLK = 1'b0;
    logic               ASYNCRESETN;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SRC_W-1:0]   out_src;
    logic [OCC_W-1:0]   occupancy;

    int vectors     = 0;
    int miscompares = 0;

    // Model: entries in acceptance order plus the next-priority channel.
    logic [SRC_W+WIDTH-1:0] q [$];
    int                     prio_m = 0;

    always #5 CLK = ~CLK;

    rr_handshake_merge #(.WIDTH(WIDTH), .N(N), .DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src     (out_src),
        .occupancy   (occupancy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model every cycle, then advance the model.
    always @(negedge CLK) begin
        logic [N-1:0] exp_ready;
        int           g;
        bit           found;
        bit           pop;
        bit           can_push;
        if (!ASYNCRESETN) begin
            q.delete();
            prio_m = 0;
            chk("rst_in_ready",  32'(in_ready),  0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_occupancy", 32'(occupancy), 0);
            chk("rst_out_data",  32'(out_data),  0);
            chk("rst_out_src",   32'(out_src),   0);
        end else begin
            found = 0;
            g     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && in_valid[(prio_m + k) % N]) begin
                    found = 1;
                    g     = (prio_m + k) % N;
                end
            end
            pop       = (q.size() > 0) && out_ready;
            can_push  = (q.size() < DEPTH) || pop;
            exp_ready = (found && can_push) ? N'(1 << g) : '0;
            chk("in_ready",  32'(in_ready),  32'(exp_ready));
            chk("out_valid", 32'(out_valid), (q.size() > 0) ? 1 : 0);
            chk("occupancy", 32'(occupancy), q.size());
            if (q.size() > 0) begin
                chk("out_data", 32'(out_data), 32'(q[0][WIDTH-1:0]));
                chk("out_src",  32'(out_src),  32'(q[0][WIDTH +: SRC_W]));
            end
            if (pop) void'(q.pop_front());
            if (found && can_push) begin
                q.push_back({SRC_W'(g), in_data[g*WIDTH +: WIDTH]});
                prio_m = (g + 1) % N;
            end
        end
    end

    // Offer one word on a channel until it is accepted; returns at posedge+1.
    task automatic push_one(input int ch, input logic [WIDTH-1:0] d);
        bit acc;
        bit ok;
        ok = 0;
        in_data[ch*WIDTH +: WIDTH] = d;
        in_valid[ch] = 1'b1;
        for (int c = 0; c < 8 && !ok; c++) begin
            @(negedge CLK);
            acc = in_ready[ch];
            @(posedge CLK);
            #1;
            if (acc) ok = 1;
        end
        in_valid[ch] = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: ch %0d never accepted, expected accept within 8 cycles", ch);
        end
    endtask

    int rr_src [6] = '{0, 1, 2, 0, 1, 2};
    int rr_dat [6] = '{1, 2, 3, 1, 2, 3};

    initial begin
        ASYNCRESETN = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 1'b0;

        // Reset held for three cycles with no requests.
        repeat (3) @(posedge CLK);
        #1 ASYNCRESETN = 1'b1;
        chk("idle_in_ready",  32'(in_ready),  0);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_occupancy", 32'(occupancy), 0);
        @(posedge CLK); #1;

        // Round-robin fairness with all channels requesting.
        in_data   = {5'h03, 5'h02, 5'h01};
        out_ready = 1'b1;
        in_valid  = 3'b111;
        @(posedge CLK); #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("rr_valid", 32'(out_valid), 1);
            chk("rr_src",   32'(out_src),   rr_src[i]);
            chk("rr_data",  32'(out_data),  rr_dat[i]);
        end
        @(posedge CLK); #1 in_valid = '0;
        repeat (3) @(posedge CLK);
        #1;

        // Backpressure fill, then full with simultaneous push and pop.
        out_ready = 1'b0;
        in_valid  = 3'b001;
        in_data[4:0] = 5'h0A;
        @(negedge CLK);
        chk("bp_ready0", 32'(in_ready), 32'b001);
        @(posedge CLK); #1 in_data[4:0] = 5'h0B;
        @(negedge CLK);
        chk("bp_occ1",   32'(occupancy), 1);
        chk("bp_ready1", 32'(in_ready),  32'b001);
        @(posedge CLK); #1;
        in_valid = 3'b100;
        in_data[14:10] = 5'h1F;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("full_ready", 32'(in_ready),  0);
            chk("full_occ",   32'(occupancy), 2);
            chk("full_head",  32'(out_data),  32'h0A);
            @(posedge CLK); #1;
        end
        out_ready = 1'b1;
        @(negedge CLK);
        chk("fpp_ready", 32'(in_ready),  32'b100);
        chk("fpp_occ",   32'(occupancy), 2);
        chk("fpp_head",  32'(out_data),  32'h0A);
        @(posedge CLK); #1 in_valid = '0;
        @(negedge CLK);
        chk("fpp_second",   32'(out_data),  32'h0B);
        chk("fpp_occ_hold", 32'(occupancy), 2);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("fpp_third", 32'(out_data), 32'h1F);
        chk("fpp_src",   32'(out_src),  2);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("fpp_drained", 32'(occupancy), 0);
        @(posedge CLK); #1;

        // Pointer and priority wrap: alternate ch2 / ch0.
        for (int i = 0; i < 10; i++) begin
            push_one((i % 2 == 1) ? 0 : 2, WIDTH'(i + 4));
        end
        // Last grant was ch0, so ch1 wins over ch0.
        in_data[4:0] = 5'h07;
        in_data[9:5] = 5'h08;
        in_valid     = 3'b011;
        @(negedge CLK);
        chk("wrap_prio", 32'(in_ready), 32'b010);
        @(posedge CLK); #1 in_valid = 3'b001;
        @(negedge CLK);
        chk("single_req", 32'(in_ready), 32'b001);
        @(posedge CLK); #1 in_valid = '0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset mid-operation with two queued entries.
        out_ready = 1'b0;
        push_one(0, 5'h11);
        push_one(1, 5'h12);
        @(negedge CLK);
        chk("pre_rst_occ", 32'(occupancy), 2);
        @(posedge CLK);
        #3 ASYNCRESETN = 1'b0;
        #1;
        chk("async_occ",   32'(occupancy), 0);
        chk("async_valid", 32'(out_valid), 0);
        chk("async_ready", 32'(in_ready),  0);
        @(posedge CLK); #1 ASYNCRESETN = 1'b1;
        out_ready = 1'b1;
        push_one(1, 5'h15);
        @(negedge CLK);
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_data",  32'(out_data),  32'h15);
        chk("post_rst_src",   32'(out_src),   1);
        chk("post_rst_occ",   32'(occupancy), 1);
        repeat (3) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
